// File: rtl/csi2_frame_sequencer.sv
// Frames decoded CSI-2 packets on one VC/data type into 32-bit beats with sof/eol/keep markers.
// All outputs registered, 1-cycle latency from image_data_enable; no backpressure, 1 beat/cycle.
module csi2_frame_sequencer #(
  parameter logic [1:0] target_vc = 2'd0,
  parameter logic [5:0] target_dt = 6'h1E
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] expected_lines,
  input  logic        header_valid,
  input  logic [1:0]  virtual_channel,
  input  logic [5:0]  data_type,
  input  logic [15:0] word_count,
  input  logic [31:0] image_data,
  input  logic        image_data_enable,
  input  logic        error_clear,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic [3:0]  out_keep,
  output logic        out_sof,
  output logic        out_eol,
  output logic [15:0] frame_number,
  output logic [15:0] line_count,
  output logic        frame_done,
  output logic        err_frame_seq,
  output logic        err_line_count,
  output logic        err_truncated,
  output logic        err_overrun
);

  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;

  typedef enum logic [1:0] {IDLE, FRAME, LINE} state_t;

  state_t      state;
  logic [14:0] beats_left;
  logic [3:0]  last_keep;
  logic        sof_pending;
  logic        foreign;

  logic        is_fs;
  logic        is_fe;
  logic        is_dt;
  logic        hdr_acc;
  logic [14:0] wc_beats;
  logic [3:0]  wc_keep;
  logic [15:0] line_inc;

  assign is_fs    = (data_type == DT_FS);
  assign is_fe    = (data_type == DT_FE);
  assign is_dt    = (data_type == target_dt);
  assign hdr_acc  = header_valid && (virtual_channel == target_vc) && (is_fs || is_fe || is_dt);
  assign wc_beats = {1'b0, word_count[15:2]} + {14'd0, |word_count[1:0]};
  assign line_inc = (line_count == 16'hFFFF) ? line_count : line_count + 16'd1;

  always_comb begin
    case (word_count[1:0])
      2'd0:    wc_keep = 4'hF;
      2'd1:    wc_keep = 4'h1;
      2'd2:    wc_keep = 4'h3;
      default: wc_keep = 4'h7;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      beats_left     <= '0;
      last_keep      <= '0;
      sof_pending    <= 1'b0;
      foreign        <= 1'b0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_keep       <= 4'h0;
      out_sof        <= 1'b0;
      out_eol        <= 1'b0;
      frame_number   <= '0;
      line_count     <= '0;
      frame_done     <= 1'b0;
      err_frame_seq  <= 1'b0;
      err_line_count <= 1'b0;
      err_truncated  <= 1'b0;
      err_overrun    <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_keep   <= 4'h0;
      frame_done <= 1'b0;

      // Later set assignments in this block override the clear.
      if (error_clear) begin
        err_frame_seq  <= 1'b0;
        err_line_count <= 1'b0;
        err_truncated  <= 1'b0;
        err_overrun    <= 1'b0;
      end

      // Headers never overlap payload in a well-formed stream, so a coincident beat is dropped.
      if (hdr_acc) begin
        foreign <= 1'b0;
        if (state == LINE) err_truncated <= 1'b1;
        if (state == IDLE) begin
          if (is_fs && enable) begin
            state        <= FRAME;
            frame_number <= word_count;
            line_count   <= '0;
            sof_pending  <= 1'b1;
          end else if (is_fe) begin
            err_frame_seq <= 1'b1;
          end
        end else begin
          state <= FRAME;
          if (is_fs) begin
            err_frame_seq <= 1'b1;
            frame_number  <= word_count;
            line_count    <= '0;
            sof_pending   <= 1'b1;
          end else if (is_fe) begin
            state       <= IDLE;
            frame_done  <= 1'b1;
            sof_pending <= 1'b0;
            if (expected_lines != 16'd0 && line_count != expected_lines) err_line_count <= 1'b1;
          end else if (word_count != 16'd0) begin
            state      <= LINE;
            beats_left <= wc_beats;
            last_keep  <= wc_keep;
          end else begin
            line_count <= line_inc;
          end
        end
      end else if (header_valid) begin
        // Payload of an ignored packet between lines must not count as overrun.
        if (state != LINE) foreign <= 1'b1;
      end else if (image_data_enable) begin
        if (state == LINE) begin
          out_valid   <= 1'b1;
          out_data    <= image_data;
          out_sof     <= sof_pending;
          sof_pending <= 1'b0;
          if (beats_left == 15'd1) begin
            out_eol    <= 1'b1;
            out_keep   <= last_keep;
            line_count <= line_inc;
            state      <= FRAME;
          end else begin
            out_keep   <= 4'hF;
            beats_left <= beats_left - 15'd1;
          end
        end else if (state == FRAME && !foreign) begin
          err_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_csi2_frame_sequencer.sv
// Self-checking bench: vector table, directed corner sequences, random frames vs a packet-level model.
module tb_csi2_frame_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, enable, header_valid, image_data_enable, error_clear;
  logic [15:0] expected_lines, word_count;
  logic [1:0]  virtual_channel;
  logic [5:0]  data_type;
  logic [31:0] image_data;
  logic [31:0] out_data;
  logic        out_valid, out_sof, out_eol, frame_done;
  logic [3:0]  out_keep;
  logic [15:0] frame_number, line_count;
  logic        err_frame_seq, err_line_count, err_truncated, err_overrun;
  logic [3:0]  err_vec;

  assign err_vec = {err_frame_seq, err_line_count, err_truncated, err_overrun};

  csi2_frame_sequencer dut (
    .clock(clock), .reset(reset), .enable(enable), .expected_lines(expected_lines),
    .header_valid(header_valid), .virtual_channel(virtual_channel), .data_type(data_type),
    .word_count(word_count), .image_data(image_data), .image_data_enable(image_data_enable),
    .error_clear(error_clear), .out_data(out_data), .out_valid(out_valid), .out_keep(out_keep),
    .out_sof(out_sof), .out_eol(out_eol), .frame_number(frame_number), .line_count(line_count),
    .frame_done(frame_done), .err_frame_seq(err_frame_seq), .err_line_count(err_line_count),
    .err_truncated(err_truncated), .err_overrun(err_overrun)
  );

  localparam logic [5:0] FS = 6'h00, FE = 6'h01, DT = 6'h1E;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        sof;
    logic        eol;
  } beat_t;

  beat_t exp_q[$];
  bit    mon_en  = 1'b0;
  int    fd_seen = 0;

  task automatic tick();
    @(posedge clock);
    #1;
    if (frame_done) fd_seen++;
    if (mon_en && out_valid) begin
      if (exp_q.size() == 0) begin
        check("rand.unexpected_beat", out_valid, 1'b0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("rand.data", out_data, e.d);
        check("rand.keep", out_keep, e.k);
        check("rand.sof", out_sof, e.sof);
        check("rand.eol", out_eol, e.eol);
      end
    end
  endtask

  task automatic hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    header_valid = 1'b1; virtual_channel = vc; data_type = dt; word_count = wc;
    tick();
    header_valid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    image_data_enable = 1'b1; image_data = d;
    tick();
    image_data_enable = 1'b0;
  endtask

  task automatic clear_errors();
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
  endtask

  function automatic logic [3:0] keep_of(input int wc);
    int r;
    r = wc % 4;
    return (r == 0) ? 4'hF : 4'((4'hF) >> (4 - r));
  endfunction

  // One cycle of stimulus and the registered outputs expected after it.
  typedef struct packed {
    logic        hv;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        de;
    logic [31:0] d;
    logic        clr;
    logic        ov;
    logic [31:0] od;
    logic [3:0]  ok;
    logic        sof;
    logic        eol;
    logic        fd;
    logic [15:0] fn;
    logic [15:0] lc;
    logic [3:0]  err;
  } vec_t;

  function automatic vec_t mk(
    input logic hv, input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
    input logic de, input logic [31:0] d, input logic clr,
    input logic ov, input logic [31:0] od, input logic [3:0] ok, input logic sof, input logic eol,
    input logic fd, input logic [15:0] fn, input logic [15:0] lc, input logic [3:0] err);
    vec_t v;
    v.hv = hv; v.vc = vc; v.dt = dt; v.wc = wc; v.de = de; v.d = d; v.clr = clr;
    v.ov = ov; v.od = od; v.ok = ok; v.sof = sof; v.eol = eol;
    v.fd = fd; v.fn = fn; v.lc = lc; v.err = err;
    return v;
  endfunction

  vec_t tv[20];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; expected_lines = 16'd2; header_valid = 1'b0;
    virtual_channel = '0; data_type = '0; word_count = '0; image_data = '0;
    image_data_enable = 1'b0; error_clear = 1'b0;
    repeat (3) tick();
    check("reset.valid", out_valid, 1'b0);
    check("reset.keep", out_keep, 4'h0);
    check("reset.sof", out_sof, 1'b0);
    check("reset.eol", out_eol, 1'b0);
    check("reset.data", out_data, 32'h0);
    check("reset.frame_number", frame_number, 16'h0);
    check("reset.line_count", line_count, 16'h0);
    check("reset.frame_done", frame_done, 1'b0);
    check("reset.errors", err_vec, 4'h0);
    reset = 1'b0;
    tick();

    //         hv vc dt  wc     de d             clr ov od            ok    sof eol fd fn     lc     err
    tv[0]  = mk(1, 1, FS, 16'd9, 0, 32'h0,        0,  0, 32'h0,        4'h0, 0,  0,  0, 16'd0, 16'd0, 4'b0000);
    tv[1]  = mk(1, 1, DT, 16'd8, 0, 32'h0,        0,  0, 32'h0,        4'h0, 0,  0,  0, 16'd0, 16'd0, 4'b0000);
    tv[2]  = mk(0, 0, FS, 16'd0, 1, 32'h12345678, 0,  0, 32'h0,        4'h0, 0,  0,  0, 16'd0, 16'd0, 4'b0000);
    tv[3]  = mk(1, 1, FE, 16'd0, 0, 32'h0,        0,  0, 32'h0,        4'h0, 0,  0,  0, 16'd0, 16'd0, 4'b0000);
    tv[4]  = mk(1, 0, FS, 16'd7, 0, 32'h0,        0,  0, 32'h0,        4'h0, 0,  0,  0, 16'd7, 16'd0, 4'b0000);
    tv[5]  = mk(1, 0, DT, 16'd8, 0, 32'h0,        0,  0, 32'h0,        4'h0, 0,  0,  0, 16'd7, 16'd0, 4'b0000);
    tv[6]  = mk(0, 0, FS, 16'd0, 1, 32'hDEADBEEF, 0,  1, 32'hDEADBEEF, 4'hF, 1,  0,  0, 16'd7, 16'd0, 4'b0000);
    tv[7]  = mk(0, 0, FS, 16'd0, 1, 32'h0D15EA5E, 0,  1, 32'h0D15EA5E, 4'hF, 0,  1,  0, 16'd7, 16'd1, 4'b0000);
    tv[8]  = mk(1, 0, DT, 16'd8, 0, 32'h0,        0,  0, 32'h0,        4'h0, 0,  0,  0, 16'd7, 16'd1, 4'b0000);
    tv[9]  = mk(0, 0, FS, 16'd0, 1, 32'h11111111, 0,  1, 32'h11111111, 4'hF, 0,  0,  0, 16'd7, 16'd1, 4'b0000);
    tv[10] = mk(0, 0, FS, 16'd0, 1, 32'h22222222, 0,  1, 32'h22222222, 4'hF, 0,  1,  0, 16'd7, 16'd2, 4'b0000);
    tv[11] = mk(1, 0, FE, 16'd0, 0, 32'h0,        0,  0, 32'h0,        4'h0, 0,  0,  1, 16'd7, 16'd2, 4'b0000);
    tv[12] = mk(0, 0, FS, 16'd0, 0, 32'h0,        0,  0, 32'h0,        4'h0, 0,  0,  0, 16'd7, 16'd2, 4'b0000);
    tv[13] = mk(1, 0, FS, 16'd1, 0, 32'h0,        0,  0, 32'h0,        4'h0, 0,  0,  0, 16'd1, 16'd0, 4'b0000);
    tv[14] = mk(1, 0, DT, 16'd6, 0, 32'h0,        0,  0, 32'h0,        4'h0, 0,  0,  0, 16'd1, 16'd0, 4'b0000);
    tv[15] = mk(0, 0, FS, 16'd0, 1, 32'hA5A5A5A5, 0,  1, 32'hA5A5A5A5, 4'hF, 1,  0,  0, 16'd1, 16'd0, 4'b0000);
    tv[16] = mk(0, 0, FS, 16'd0, 1, 32'h00C0FFEE, 0,  1, 32'h00C0FFEE, 4'h3, 0,  1,  0, 16'd1, 16'd1, 4'b0000);
    tv[17] = mk(1, 0, FE, 16'd0, 0, 32'h0,        0,  0, 32'h0,        4'h0, 0,  0,  1, 16'd1, 16'd1, 4'b0100);
    tv[18] = mk(1, 0, FE, 16'd0, 0, 32'h0,        0,  0, 32'h0,        4'h0, 0,  0,  0, 16'd1, 16'd1, 4'b1100);
    tv[19] = mk(0, 0, FS, 16'd0, 0, 32'h0,        1,  0, 32'h0,        4'h0, 0,  0,  0, 16'd1, 16'd1, 4'b0000);

    for (int i = 0; i < 20; i++) begin
      header_valid = tv[i].hv; virtual_channel = tv[i].vc; data_type = tv[i].dt;
      word_count = tv[i].wc; image_data_enable = tv[i].de; image_data = tv[i].d;
      error_clear = tv[i].clr;
      tick();
      header_valid = 1'b0; image_data_enable = 1'b0; error_clear = 1'b0;
      check($sformatf("vec%0d.valid", i), out_valid, tv[i].ov);
      if (tv[i].ov) begin
        check($sformatf("vec%0d.data", i), out_data, tv[i].od);
        check($sformatf("vec%0d.keep", i), out_keep, tv[i].ok);
      end
      check($sformatf("vec%0d.sof", i), out_sof, tv[i].sof);
      check($sformatf("vec%0d.eol", i), out_eol, tv[i].eol);
      check($sformatf("vec%0d.frame_done", i), frame_done, tv[i].fd);
      check($sformatf("vec%0d.frame_number", i), frame_number, tv[i].fn);
      check($sformatf("vec%0d.line_count", i), line_count, tv[i].lc);
      check($sformatf("vec%0d.errors", i), err_vec, tv[i].err);
    end

    // Truncated line closed by FE.
    expected_lines = 16'd0;
    hdr(0, FS, 16'd3);
    hdr(0, DT, 16'd16);
    beat(32'h1);
    beat(32'h2);
    check("trunc.beat2_valid", out_valid, 1'b1);
    check("trunc.beat2_no_eol", out_eol, 1'b0);
    hdr(0, FE, 16'd0);
    check("trunc.frame_done", frame_done, 1'b1);
    check("trunc.errors", err_vec, 4'b0010);
    check("trunc.line_count", line_count, 16'd0);
    clear_errors();

    // Overrun, then FS inside an open frame.
    hdr(0, FS, 16'd4);
    beat(32'h3);
    check("overrun.valid", out_valid, 1'b0);
    check("overrun.errors", err_vec, 4'b0001);
    hdr(0, DT, 16'd0);
    check("zero_wc.line_count", line_count, 16'd1);
    hdr(0, FS, 16'd5);
    check("fs_in_frame.errors", err_vec, 4'b1001);
    check("fs_in_frame.frame_number", frame_number, 16'd5);
    check("fs_in_frame.line_count", line_count, 16'd0);
    hdr(0, FE, 16'd0);
    clear_errors();
    check("clear.errors", err_vec, 4'b0000);

    // Dropping enable mid-frame only takes effect once back in IDLE.
    hdr(0, FS, 16'd6);
    enable = 1'b0;
    hdr(0, DT, 16'd4);
    beat(32'hCAFEF00D);
    check("en_mid.valid", out_valid, 1'b1);
    check("en_mid.sof", out_sof, 1'b1);
    check("en_mid.eol", out_eol, 1'b1);
    hdr(0, FE, 16'd0);
    check("en_mid.frame_done", frame_done, 1'b1);
    hdr(0, FS, 16'd8);
    check("en_off.frame_number", frame_number, 16'd6);
    beat(32'h4);
    check("en_off.valid", out_valid, 1'b0);
    check("en_off.errors", err_vec, 4'b0000);
    enable = 1'b1;

    // Maximum word count: 16384 beats.
    begin
      int n_valid, n_eol;
      logic [3:0] k_last;
      logic e_last;
      n_valid = 0; n_eol = 0; k_last = 4'h0; e_last = 1'b0;
      hdr(0, FS, 16'd9);
      hdr(0, DT, 16'hFFFF);
      for (int b = 0; b < 16384; b++) begin
        beat(32'(b));
        if (out_valid) n_valid++;
        if (out_eol) n_eol++;
        if (b == 16383) begin
          k_last = out_keep;
          e_last = out_eol;
        end
      end
      check("max.beats", n_valid, 16384);
      check("max.eol_count", n_eol, 1);
      check("max.last_keep", k_last, 4'h7);
      check("max.last_eol", e_last, 1'b1);
      check("max.line_count", line_count, 16'd1);
      hdr(0, FE, 16'd0);
    end

    // Reset during beat 2 of 4.
    hdr(0, FS, 16'd2);
    hdr(0, DT, 16'd16);
    beat(32'h5);
    reset = 1'b1; image_data_enable = 1'b1; image_data = 32'h6;
    tick();
    reset = 1'b0; image_data_enable = 1'b0;
    check("rst_mid.valid", out_valid, 1'b0);
    check("rst_mid.eol", out_eol, 1'b0);
    check("rst_mid.data", out_data, 32'h0);
    check("rst_mid.keep", out_keep, 4'h0);
    check("rst_mid.frame_number", frame_number, 16'h0);
    check("rst_mid.line_count", line_count, 16'h0);
    check("rst_mid.errors", err_vec, 4'h0);
    beat(32'h7);
    check("rst_idle.valid", out_valid, 1'b0);
    check("rst_idle.no_overrun", err_overrun, 1'b0);
    hdr(0, FS, 16'd3);
    hdr(0, DT, 16'd4);
    beat(32'h8);
    check("rst_restart.valid", out_valid, 1'b1);
    check("rst_restart.sof", out_sof, 1'b1);
    check("rst_restart.frame_number", frame_number, 16'd3);
    hdr(0, FE, 16'd0);
    clear_errors();

    // Random well-formed frames with ignored foreign packets, against a packet-level model.
    mon_en = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int nl, el, fd_before;
      logic [15:0] fn;
      bit first;
      el = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4);
      expected_lines = 16'(el);
      clear_errors();
      fn = 16'($urandom);
      fd_before = fd_seen;
      first = 1'b1;
      hdr(0, FS, fn);
      nl = $urandom_range(0, 4);
      for (int l = 0; l < nl; l++) begin
        int wc, nb;
        if ($urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 0) hdr(2'($urandom_range(1, 3)), DT, 16'd8);
          else hdr(0, 6'h12, 16'd8);
          repeat ($urandom_range(1, 2)) beat($urandom);
        end
        wc = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 40);
        nb = (wc + 3) / 4;
        hdr(0, DT, 16'(wc));
        for (int b = 0; b < nb; b++) begin
          beat_t e;
          e.d   = $urandom;
          e.k   = (b == nb - 1) ? keep_of(wc) : 4'hF;
          e.sof = first && (b == 0);
          e.eol = (b == nb - 1);
          exp_q.push_back(e);
          beat(e.d);
          if ($urandom_range(0, 3) == 0) tick();
        end
        if (nb > 0) first = 1'b0;
      end
      hdr(0, FE, 16'($urandom));
      check($sformatf("rand%0d.frame_done", f), fd_seen - fd_before, 1);
      check($sformatf("rand%0d.pending_beats", f), exp_q.size(), 0);
      check($sformatf("rand%0d.frame_number", f), frame_number, fn);
      check($sformatf("rand%0d.line_count", f), line_count, 16'(nl));
      check($sformatf("rand%0d.errors", f), err_vec, {1'b0, (el != 0 && nl != el), 2'b00});
      exp_q.delete();
    end
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csi2_frame_sequencer.md
# csi2_frame_sequencer

Sequences the decoded CSI-2 packet stream from the `camera` receiver into framed pixel traffic for downstream consumers. It tracks Frame Start/End and data packets on one configured virtual channel and data type. It forwards 32-bit payload beats with start-of-frame, end-of-line and byte-keep markers, and counts lines and frames. Protocol violations are reported through sticky error flags. It sits directly after `camera` and in front of line buffers and ISP logic.

## Interface
- `target_vc`, 2'd0, virtual channel accepted; all other VCs are ignored.
- `target_dt`, 6'h1E, data type of forwarded long packets (default YUV422 8-bit).
- `clock` in 1: single clock domain, rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: arms capture; sampled only in IDLE.
- `expected_lines` in 16: lines per frame; 0 disables the line-count check.
- `header_valid` in 1: one-cycle strobe when a packet header is decoded.
- `virtual_channel` in 2, `data_type` in 6, `word_count` in 16: header fields, valid with `header_valid`.
- `image_data` in 32: payload beat, byte 0 in [7:0].
- `image_data_enable` in 1: payload beat valid.
- `error_clear` in 1: clears all sticky errors.
- `out_data` out 32, `out_valid` out 1, `out_keep` out 4: forwarded beat and its valid byte lanes.
- `out_sof` out 1: first beat of a frame. `out_eol` out 1: last beat of a line.
- `frame_number` out 16: word count of the last accepted Frame Start.
- `line_count` out 16: lines completed in the current frame.
- `frame_done` out 1: one-cycle pulse on the accepted Frame End.
- `err_frame_seq`, `err_line_count`, `err_truncated`, `err_overrun` out 1 each: sticky error flags.

## Operation
- Only headers with `virtual_channel == target_vc` are considered; all other headers and beats are ignored.
- Data types: FS = 0x00, FE = 0x01, data = `target_dt`. Other types are ignored, including line start/end.
- FSM states and transitions:
  - IDLE: FS with `enable` = 1 → FRAME. Capture `frame_number`, clear `line_count`, set the sof-pending flag. FE in IDLE → `err_frame_seq`.
  - FRAME, on data header:
    - `word_count` ≠ 0 → LINE. Load `beats_left = (word_count+3)>>2` (17-bit intermediate, no overflow at 0xFFFF) and `last_keep`, where `word_count[1:0]` = 0 gives 4'hF, else the lowest N bits set.
    - `word_count` = 0 → `line_count`+1 and stay in FRAME.
  - FRAME, on FE → IDLE. Pulse `frame_done`. If `expected_lines` ≠ 0 and `line_count` ≠ `expected_lines`, set `err_line_count`.
  - FRAME, on FS → `err_frame_seq`. Restart the frame: new `frame_number`, `line_count` = 0.
  - LINE: each `image_data_enable` forwards one beat and decrements `beats_left`.
    - Final beat: `out_eol` = 1, `out_keep` = `last_keep`, `line_count`+1 → FRAME.
    - Any accepted header while in LINE sets `err_truncated`, closes the line without `out_eol`, and is then processed as in FRAME in the same cycle.
- Beat in FRAME or IDLE (no open line) → dropped; `err_overrun` is set in FRAME only.
- `out_sof` is set on the first forwarded beat after FS; the sof-pending flag then clears.
- `enable` deasserted mid-frame has no effect until FE returns the FSM to IDLE.
- `line_count` saturates at 0xFFFF.
- Error flags: set has priority over `error_clear` in the same cycle.

## Timing
- Reset values: FSM = IDLE; all outputs 0 except `out_keep` = 4'h0; `frame_number` = 0; `line_count` = 0; all errors 0.
- All outputs are registered.
- `out_*` follows `image_data_enable` by exactly 1 cycle; `out_valid` is never asserted without an input beat.
- `frame_done` and error flags assert 1 cycle after the causing strobe.
- `line_count` updates in the same cycle as the `out_eol` beat.
- There is no backpressure; throughput is 1 beat/cycle.
- Reset mid-line drops the line, emits no `out_eol`, and the FSM is in IDLE on the next cycle.

## Test plan
- FS(wc=0x0007), 2× data(wc=8, beats 0xDEADBEEF, 0x0D15EA5E), FE with `expected_lines`=2:
  - 4 `out_valid` beats; `out_sof` on beat 1; `out_eol` on beats 2 and 4.
  - `frame_number` = 7; `frame_done` pulses once; no errors.
- Data wc=6 → 2 beats; second beat has `out_keep` = 4'h3 and `out_eol`. wc=0xFFFF → 16384 beats with final `out_keep` = 4'h7.
- Same frame on `virtual_channel` = 1 with `target_vc` = 0 → no `out_valid`, `line_count` stays 0, no errors.
- Sequence violations:
  - FE in IDLE → `err_frame_seq`.
  - FE after 1 line with `expected_lines` = 2 → `err_line_count`.
  - `error_clear` → all flags 0.
- Truncation and overrun:
  - Data wc=16, 2 beats, then FE → `err_truncated`, no `out_eol`, `frame_done` pulses.
  - An extra beat in FRAME → `err_overrun`.
- `reset` asserted during beat 2 of 4 → the next cycle shows IDLE and all outputs at reset values. A subsequent FS with `enable` = 1 restarts cleanly with `out_sof`.
